alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// Two-stage valid/ready execute pipeline around the combinational alu. Registers
// operands into stage 1 and drives the alu from them. Captures alu result plus tag in
// stage 2 and presents it downstream. Flags reserved opcodes and counts retired results.
// PARAMETERS
// WIDTH  32  operand/result width; must match alu
// TAG_W  4   width of sideband tag carried with each operation
// CNT_W  16  width of retired-result counter
// PORTS
// i_clk      in   1      clock, all state on rising edge
// i_rst      in   1      synchronous reset, active-high
// i_valid    in   1      upstream command valid
// o_ready    out  1      stage can accept command this cycle
// i_a        in   WIDTH  operand a
// i_b        in   WIDTH  operand b
// i_op       in   4      alu opcode (0000 add, 0001 sub, 0011 slt, 0100 sltu, ...)
// i_tag      in   TAG_W  sideband tag, returned unchanged with result
// o_alu_a    out  WIDTH  to alu i_a = stage-1 operand a
// o_alu_b    out  WIDTH  to alu i_b = stage-1 operand b
// o_alu_op   out  4      to alu i_op = stage-1 opcode
// i_alu_res  in   WIDTH  from alu o_res (combinational)
// o_valid    out  1      result valid
// i_ready    in   1      downstream accepts result
// o_res      out  WIDTH  result
// o_tag      out  TAG_W  tag of result
// o_err      out  1      result came from reserved opcode 4'b1111
// o_count    out  CNT_W  number of results retired (o_valid & i_ready)
// BEHAVIOUR
// - Reset (i_rst high at edge): s1_valid=0, s2_valid=0, o_valid=0, o_res=0, o_tag=0,
//   o_err=0, o_count=0, stage-1 regs=0 (so o_alu_* = 0). Reset wins over any handshake.
// - Reset mid-operation discards all in-flight commands; nothing is emitted for them.
// - Stage-2 load: s2_load = s1_valid & (!s2_valid | i_ready).
// - o_ready = !s1_valid | s2_load (combinational path i_ready -> o_ready is allowed).
// - Accept: i_valid & o_ready at edge -> stage 1 <= {i_a,i_b,i_op,i_tag}, s1_valid<=1.
//   If s2_load and no accept, s1_valid<=0. Inputs ignored when i_valid=0.
// - s2_load at edge: o_res <= (op==4'b1111) ? 0 : i_alu_res; o_tag <= s1 tag;
//   o_err <= (op==4'b1111); s2_valid<=1. Else if i_ready: s2_valid<=0.
// - o_valid = s2_valid. o_res/o_tag/o_err held stable while o_valid & !i_ready.
// - Latency: command accepted at edge E0 appears with o_valid=1 after edge E1
//   (2 edges). Throughput 1/cycle with i_ready held high.
// - Backpressure: i_ready low holds stage 2; stage 1 fills; o_ready drops once both
//   full. Max 2 commands in flight. No command dropped, duplicated or reordered.
// - Simultaneous accept and stage-1 drain in same edge: stage 1 takes new command.
// - o_count increments by 1 per edge with o_valid & i_ready; wraps 2^CNT_W-1 -> 0.
// - Width rules: operands/result passed unmodified; no truncation or extension here.
// TESTING
// Bench instantiates real alu, wiring o_alu_*/i_alu_res.
// 1 a=-1,b=11: op 0000 -> res 10; 0001 -> -12; 0011 -> 1; 0100 -> 0; each 2 edges after accept, tags 1..4 in order.
// 2 Back-to-back 8 cmds, i_ready=1 -> o_valid high 8 consecutive cycles, o_count=8.
// 3 i_ready=0 for 5 cycles while i_valid=1 -> exactly 2 accepted, o_ready=0 afterwards,
//   o_res stable; release i_ready -> results drain in order, no loss.
// 4 op=4'b1111, tag=7 -> o_res=0, o_err=1, o_tag=7; next legal op -> o_err=0.
// 5 i_rst pulsed with 2 cmds in flight -> o_valid=0, o_count=0 next cycle; flushed tags never appear.
// 6 CNT_W=4, retire 17 results -> o_count=1 (wrap checked).

Source files
------------

// File: rtl/alu_exec_stage.sv
// Two-stage valid/ready execute pipeline wrapped around an external combinational ALU.
// Stage 1 holds the operands that drive the ALU; stage 2 captures the result and tag.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_res,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_err,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [3:0] OP_RESERVED = 4'b1111;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_load;
  logic             accept;
  logic             reserved;

  // Stage 2 drains into downstream and refills from stage 1 in the same edge,
  // which is what lets a full pipeline keep accepting one command per cycle.
  assign s2_load  = s1_valid & (~s2_valid | i_ready);
  assign o_ready  = ~s1_valid | s2_load;
  assign accept   = i_valid & o_ready;
  assign reserved = (s1_op == OP_RESERVED);

  assign o_alu_a  = s1_a;
  assign o_alu_b  = s1_b;
  assign o_alu_op = s1_op;
  assign o_valid  = s2_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      o_res    <= '0;
      o_tag    <= '0;
      o_err    <= 1'b0;
      o_count  <= '0;
    end else begin
      if (accept) begin
        s1_a     <= i_a;
        s1_b     <= i_b;
        s1_op    <= i_op;
        s1_tag   <= i_tag;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      // Reserved opcodes never expose whatever the ALU happens to produce.
      if (s2_load) begin
        o_res    <= reserved ? '0 : i_alu_res;
        o_tag    <= s1_tag;
        o_err    <= reserved;
        s2_valid <= 1'b1;
      end else if (i_ready) begin
        s2_valid <= 1'b0;
      end

      if (s2_valid && i_ready) begin
        o_count <= o_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed commands push expected results,
// a negedge monitor compares every presented result and the retired-result counters.
module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [3:0]  i_op;
  logic [3:0]  i_tag;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_alu_a, o_alu_b, i_alu_res, o_res;
  logic [3:0]  o_alu_op, o_tag;
  logic [15:0] o_count;

  logic        o_ready_n, o_valid_n, o_err_n;
  logic [31:0] o_alu_a_n, o_alu_b_n, i_alu_res_n, o_res_n;
  logic [3:0]  o_alu_op_n, o_tag_n;
  logic [3:0]  o_count_n;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = '0;
  logic [3:0]  exp_count_n = '0;
  int          cur_run = 0;
  int          max_run = 0;

  always #5 i_clk = ~i_clk;

  // Stand-in for the real combinational ALU; unknown opcodes give a loud pattern.
  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = {31'd0, $signed(a) < $signed(b)};
      4'b0100: r = {31'd0, a < b};
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  always_comb i_alu_res   = aluModel(o_alu_op, o_alu_a, o_alu_b);
  always_comb i_alu_res_n = aluModel(o_alu_op_n, o_alu_a_n, o_alu_b_n);

  alu_exec_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_tag(i_tag),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_res(i_alu_res),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_tag(o_tag),
    .o_err(o_err), .o_count(o_count)
  );

  alu_exec_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(4)) dut_narrow (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_n),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_tag(i_tag),
    .o_alu_a(o_alu_a_n), .o_alu_b(o_alu_b_n), .o_alu_op(o_alu_op_n), .i_alu_res(i_alu_res_n),
    .o_valid(o_valid_n), .i_ready(i_ready), .o_res(o_res_n), .o_tag(o_tag_n),
    .o_err(o_err_n), .o_count(o_count_n)
  );

  // Monitor: every cycle a result is presented it must match the queue head,
  // and the retired-result counters must track the model.
  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
      exp_count   = '0;
      exp_count_n = '0;
    end else begin
      checks++;
      if (o_count !== exp_count || o_count_n !== exp_count_n) begin
        errors++;
        $display("[TB] FAIL count: got %0d/%0d expected %0d/%0d", o_count, o_count_n, exp_count, exp_count_n);
      end
      if (o_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got res=%h tag=%0d with no command outstanding", o_res, o_tag);
        end else if ({o_res, o_tag, o_err} !== q[0] || {o_res_n, o_tag_n, o_err_n} !== q[0]) begin
          errors++;
          $display("[TB] FAIL scoreboard: got res=%h tag=%0d err=%0b expected res=%h tag=%0d err=%0b",
                   o_res, o_tag, o_err, q[0].res, q[0].tag, q[0].err);
        end
        if (i_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          exp_count   = exp_count + 16'd1;
          exp_count_n = exp_count_n + 4'd1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      cur_run = 0;
      max_run = 0;
    end else begin
      cur_run = o_valid ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one command and holds it until accepted; leaves i_valid high so
  // consecutive calls stream at full rate.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                               input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_err);
    bit accepted = 0;
    i_a = a; i_b = b; i_op = op; i_tag = tag; i_valid = 1'b1;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge i_clk);
      if (o_ready) begin
        q.push_back({exp_res, tag, exp_err});
        accepted = 1;
      end
      @(posedge i_clk); #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: tag %0d never accepted, expected acceptance within 20 cycles", tag);
    end
  endtask

  task automatic resetDut();
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    checkOutput("drain", q.size(), 0);
  endtask

  task automatic latencyCmd(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] exp_res);
    applyStimulus(32'hFFFF_FFFF, 32'd11, op, tag, exp_res, 1'b0);
    i_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("latency_e0", o_valid, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checkOutput("latency_e1", o_valid, 1);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int acc;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_op = '0; i_tag = '0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;

    @(negedge i_clk);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_res", o_res, 0);
    checkOutput("rst_tag", o_tag, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_count", o_count, 0);
    checkOutput("rst_alu_a", o_alu_a, 0);
    checkOutput("rst_ready", o_ready, 1);
    @(posedge i_clk); #1;

    $display("[TB] test 1: basic ops with a=-1 b=11");
    latencyCmd(4'b0000, 4'd1, 32'd10);
    latencyCmd(4'b0001, 4'd2, 32'hFFFF_FFF4);
    latencyCmd(4'b0011, 4'd3, 32'd1);
    latencyCmd(4'b0100, 4'd4, 32'd0);
    waitDrain();

    $display("[TB] test 2: back-to-back stream");
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(32'(i), 32'd100, 4'b0000, 4'(i), 32'(100 + i), 1'b0);
    i_valid = 1'b0;
    waitDrain();
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("stream_run", max_run, 8);
    checkOutput("stream_count", o_count, 8);

    $display("[TB] test 3: backpressure");
    i_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      i_a = 32'(20 + acc); i_b = 32'd3; i_op = 4'b0001; i_tag = 4'(8 + acc); i_valid = 1'b1;
      @(negedge i_clk);
      if (o_ready) begin
        q.push_back({32'(17 + acc), 4'(8 + acc), 1'b0});
        acc++;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    checkOutput("bp_accepted", acc, 2);
    @(negedge i_clk);
    checkOutput("bp_ready", o_ready, 0);
    checkOutput("bp_valid", o_valid, 1);
    checkOutput("bp_tag", o_tag, 8);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    waitDrain();

    $display("[TB] test 4: reserved opcode");
    applyStimulus(32'd3, 32'd4, 4'b1111, 4'd7, 32'd0, 1'b1);
    applyStimulus(32'd3, 32'd4, 4'b0000, 4'd2, 32'd7, 1'b0);
    i_valid = 1'b0;
    waitDrain();

    $display("[TB] test 5: reset with commands in flight");
    i_ready = 1'b0;
    applyStimulus(32'd1, 32'd1, 4'b0000, 4'd10, 32'd2, 1'b0);
    applyStimulus(32'd2, 32'd2, 4'b0000, 4'd11, 32'd4, 1'b0);
    i_valid = 1'b0;
    resetDut();
    @(negedge i_clk);
    checkOutput("flush_valid", o_valid, 0);
    checkOutput("flush_count", o_count, 0);
    checkOutput("flush_ready", o_ready, 1);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;

    $display("[TB] test 6: counter wrap");
    for (int i = 0; i < 17; i++) applyStimulus(32'(i), 32'd1, 4'b0000, 4'(i), 32'(i + 1), 1'b0);
    i_valid = 1'b0;
    waitDrain();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("wrap_count_narrow", o_count_n, 1);
    checkOutput("wrap_count_wide", o_count, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
